// File: rtl/key_sched_pkg.sv
// Shared definitions for the round-key schedule: operation encoding, constants
// and the byte-pattern replication helper.
package key_sched_pkg;

    typedef enum logic [3:0] {
        OP_ID    = 4'd0,
        OP_ROL1  = 4'd1,
        OP_XA    = 4'd2,
        OP_ROR1  = 4'd3,
        OP_NOT   = 4'd4,
        OP_ADD   = 4'd5,
        OP_SUB   = 4'd6,
        OP_HSWAP = 4'd7,
        OP_X5    = 4'd8,
        OP_ROL2  = 4'd9,
        OP_ROL1B = 4'd10
    } op_e;

    localparam int          NUM_OPS   = 11;
    localparam logic [7:0]  ADD_CONST = 8'h1F;
    localparam logic [7:0]  PAT_A     = 8'hAA;
    localparam logic [7:0]  PAT_5     = 8'h55;

    // Bit i of a byte pattern repeated across an arbitrary width.
    function automatic logic rep_bit(input logic [7:0] pat, input int i);
        return pat[3'(i % 8)];
    endfunction

endpackage

// File: rtl/key_round_op.sv
// Single round-key transform: applies one schedule operation to an operand.
// Purely combinational; shared with the inverse-schedule block.
module key_round_op
    import key_sched_pkg::*;
#(
    parameter int KEY_W = 8
) (
    input  op_e              op,
    input  logic [KEY_W-1:0] operand,
    output logic [KEY_W-1:0] result
);

    localparam int HALF = KEY_W / 2;

    logic [KEY_W-1:0] pat_a;
    logic [KEY_W-1:0] pat_5;
    logic [KEY_W-1:0] add_c;

    // Constants are widened (or truncated, for KEY_W < 8) to the key width.
    always_comb begin
        for (int i = 0; i < KEY_W; i++) begin
            pat_a[i] = rep_bit(PAT_A, i);
            pat_5[i] = rep_bit(PAT_5, i);
            add_c[i] = (i < 8) ? ADD_CONST[3'(i % 8)] : 1'b0;
        end
    end

    always_comb begin
        // NOTE: assigning a default first keeps every path driven, so no latch is inferred.
        result = operand;
        case (op)
            OP_ID:    result = operand;
            OP_ROL1:  result = {operand[KEY_W-2:0], operand[KEY_W-1]};
            OP_XA:    result = operand ^ pat_a;
            OP_ROR1:  result = {operand[0], operand[KEY_W-1:1]};
            OP_NOT:   result = ~operand;
            OP_ADD:   result = operand + add_c;
            OP_SUB:   result = operand - add_c;
            OP_HSWAP: result = {operand[HALF-1:0], operand[KEY_W-1:HALF]};
            OP_X5:    result = operand ^ pat_5;
            OP_ROL2:  result = {operand[KEY_W-3:0], operand[KEY_W-1:KEY_W-2]};
            OP_ROL1B: result = {operand[KEY_W-2:0], operand[KEY_W-1]};
            default:  result = operand;
        endcase
    end

endmodule

// File: rtl/key_schedule_seq.sv
// Sequential round-key generator: latches a seed on start and streams
// NUM_ROUNDS keys over a valid/ready interface, seed-based or chained.
module key_schedule_seq
    import key_sched_pkg::*;
#(
    parameter int KEY_W      = 8,
    parameter int NUM_ROUNDS = 11,
    parameter int RIDX_W     = (NUM_ROUNDS > 1) ? $clog2(NUM_ROUNDS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              chain,
    input  logic [KEY_W-1:0]  key_in,
    output logic [KEY_W-1:0]  key_out,
    output logic [RIDX_W-1:0] round_idx,
    output logic              key_valid,
    input  logic              key_ready,
    output logic              key_last,
    output logic              busy,
    output logic              done
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EMIT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [RIDX_W-1:0] LAST_IDX = RIDX_W'(NUM_ROUNDS - 1);

    logic [1:0]        state_q;
    logic [KEY_W-1:0]  seed_q;
    logic [KEY_W-1:0]  key_q;
    logic              chain_q;
    logic [RIDX_W-1:0] round_q;
    op_e               op_q;

    op_e              next_op;
    logic [KEY_W-1:0] operand;
    logic [KEY_W-1:0] next_key;
    logic             last_round;

    // op_q tracks round_q mod NUM_OPS so no divider is needed.
    assign next_op    = (op_q == OP_ROL1B) ? OP_ID : op_e'(op_q + 4'd1);
    assign operand    = chain_q ? key_q : seed_q;
    assign last_round = (round_q == LAST_IDX);

    key_round_op #(.KEY_W(KEY_W)) u_round_op (
        .op      (next_op),
        .operand (operand),
        .result  (next_key)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            seed_q  <= '0;
            key_q   <= '0;
            chain_q <= 1'b0;
            round_q <= '0;
            op_q    <= OP_ID;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        seed_q  <= key_in;
                        key_q   <= key_in;
                        chain_q <= chain;
                        round_q <= '0;
                        op_q    <= OP_ID;
                        state_q <= ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    if (key_ready) begin
                        if (last_round) begin
                            state_q <= ST_DONE;
                        end else begin
                            key_q   <= next_key;
                            round_q <= round_q + RIDX_W'(1);
                            op_q    <= next_op;
                        end
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign key_out   = key_q;
    assign round_idx = round_q;
    assign key_valid = (state_q == ST_EMIT);
    assign key_last  = key_valid && last_round;
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_key_schedule_seq.sv
// Directed bench for key_schedule_seq: 8-bit/11-round, 16-bit/12-round and
// 4-bit/1-round instances checked against hand-computed key tables.
module tb_key_schedule_seq;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // 8-bit, 11-round instance
    logic       start8, chain8, ready8;
    logic [7:0] key_in8, key_out8;
    logic [3:0] idx8;
    logic       valid8, last8, busy8, done8;

    // 16-bit, 12-round instance
    logic        start16, chain16, ready16;
    logic [15:0] key_in16, key_out16;
    logic [3:0]  idx16;
    logic        valid16, last16, busy16, done16;

    // 4-bit, 1-round instance
    logic       start4, chain4, ready4;
    logic [3:0] key_in4, key_out4;
    logic [0:0] idx4;
    logic       valid4, last4, busy4, done4;

    key_schedule_seq #(.KEY_W(8), .NUM_ROUNDS(11)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .chain(chain8), .key_in(key_in8),
        .key_out(key_out8), .round_idx(idx8), .key_valid(valid8), .key_ready(ready8),
        .key_last(last8), .busy(busy8), .done(done8)
    );

    key_schedule_seq #(.KEY_W(16), .NUM_ROUNDS(12)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .chain(chain16), .key_in(key_in16),
        .key_out(key_out16), .round_idx(idx16), .key_valid(valid16), .key_ready(ready16),
        .key_last(last16), .busy(busy16), .done(done16)
    );

    key_schedule_seq #(.KEY_W(4), .NUM_ROUNDS(1)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .chain(chain4), .key_in(key_in4),
        .key_out(key_out4), .round_idx(idx4), .key_valid(valid4), .key_ready(ready4),
        .key_last(last4), .busy(busy4), .done(done4)
    );

    int total = 0;
    int bad   = 0;

    logic [7:0] seed_keys  [11] = '{8'h3C, 8'h78, 8'h96, 8'h1E, 8'hC3, 8'h5B,
                                    8'h1D, 8'hC3, 8'h69, 8'hF0, 8'h78};
    logic [7:0] chain_keys [11] = '{8'h01, 8'h02, 8'hA8, 8'h54, 8'hAB, 8'hCA,
                                    8'hAB, 8'hBA, 8'hEF, 8'hBF, 8'h7F};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Outputs are sampled 1 ns after the rising edge, inputs change there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat8(input string tag, input int r, input logic [7:0] k);
        check($sformatf("%s r%0d key", tag, r), 32'(key_out8), 32'(k));
        check($sformatf("%s r%0d idx", tag, r), 32'(idx8), 32'(r));
        check($sformatf("%s r%0d valid", tag, r), 32'(valid8), 32'd1);
        check($sformatf("%s r%0d last", tag, r), 32'(last8), (r == 10) ? 32'd1 : 32'd0);
        check($sformatf("%s r%0d done", tag, r), 32'(done8), 32'd0);
    endtask

    task automatic launch8(input logic [7:0] k, input logic ch);
        start8 = 1'b1; key_in8 = k; chain8 = ch; ready8 = 1'b1;
        tick();
        start8 = 1'b0; key_in8 = 8'h00; chain8 = 1'b0;
    endtask

    // Walks all 11 beats; optional stall and stray start at given rounds.
    task automatic stream8(input string tag, input logic [7:0] exp [11],
                           input int stall_at, input int poke_at);
        for (int r = 0; r < 11; r++) begin
            beat8(tag, r, exp[r]);
            if (r == stall_at) begin
                ready8 = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    tick();
                    beat8({tag, " stall"}, r, exp[r]);
                end
                ready8 = 1'b1;
            end
            if (r == poke_at) begin
                start8 = 1'b1; key_in8 = 8'hFF; chain8 = 1'b1;
            end
            tick();
            start8 = 1'b0; key_in8 = 8'h00; chain8 = 1'b0;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start8 = 0; chain8 = 0; ready8 = 0; key_in8 = '0;
        start16 = 0; chain16 = 0; ready16 = 0; key_in16 = '0;
        start4 = 0; chain4 = 0; ready4 = 0; key_in4 = '0;
        #12;
        check("reset key_out", 32'(key_out8), 32'd0);
        check("reset idx", 32'(idx8), 32'd0);
        check("reset valid", 32'(valid8), 32'd0);
        check("reset busy", 32'(busy8), 32'd0);
        check("reset done", 32'(done8), 32'd0);
        check("reset last", 32'(last8), 32'd0);
        rst_n = 1'b1;
        tick();

        // Seed mode, full throughput
        launch8(8'h3C, 1'b0);
        check("seed busy", 32'(busy8), 32'd1);
        stream8("seed", seed_keys, -1, -1);
        check("seed done", 32'(done8), 32'd1);
        check("seed done valid", 32'(valid8), 32'd0);
        check("seed done busy", 32'(busy8), 32'd1);
        tick();
        check("seed idle done", 32'(done8), 32'd0);
        check("seed idle busy", 32'(busy8), 32'd0);

        // Chain mode
        launch8(8'h01, 1'b1);
        stream8("chain", chain_keys, -1, -1);
        check("chain done", 32'(done8), 32'd1);
        tick();

        // Backpressure at round 2 plus ignored start at round 4
        launch8(8'h3C, 1'b0);
        stream8("bp", seed_keys, 2, 4);
        check("bp done", 32'(done8), 32'd1);
        // start during DONE must be ignored
        start8 = 1'b1; key_in8 = 8'h77;
        tick();
        check("done-start busy", 32'(busy8), 32'd0);
        check("done-start valid", 32'(valid8), 32'd0);
        // held start in IDLE is accepted
        tick();
        start8 = 1'b0; key_in8 = 8'h00;
        check("idle-start busy", 32'(busy8), 32'd1);
        check("idle-start key", 32'(key_out8), 32'h77);
        check("idle-start idx", 32'(idx8), 32'd0);
        tick();
        check("idle-start r1 key", 32'(key_out8), 32'hEE);
        for (int i = 0; i < 11; i++) tick();
        check("idle-start drained", 32'(busy8), 32'd0);

        // Reset in the middle of a stream
        launch8(8'h3C, 1'b0);
        for (int r = 0; r < 5; r++) tick();
        check("pre-reset key", 32'(key_out8), 32'h5B);
        #2 rst_n = 1'b0;
        #1;
        check("mid-reset valid", 32'(valid8), 32'd0);
        check("mid-reset busy", 32'(busy8), 32'd0);
        check("mid-reset idx", 32'(idx8), 32'd0);
        check("mid-reset key", 32'(key_out8), 32'd0);
        check("mid-reset done", 32'(done8), 32'd0);
        #2 rst_n = 1'b1;
        tick();
        check("post-reset done", 32'(done8), 32'd0);
        check("post-reset busy", 32'(busy8), 32'd0);
        launch8(8'h3C, 1'b0);
        beat8("post-reset", 0, 8'h3C);
        for (int i = 0; i < 12; i++) tick();
        check("post-reset drained", 32'(busy8), 32'd0);

        // Wide configuration
        start16 = 1'b1; key_in16 = 16'h1234; chain16 = 1'b0; ready16 = 1'b1;
        tick();
        start16 = 1'b0;
        for (int r = 0; r < 12; r++) begin
            check($sformatf("wide r%0d idx", r), 32'(idx16), 32'(r));
            check($sformatf("wide r%0d last", r), 32'(last16), (r == 11) ? 32'd1 : 32'd0);
            case (r)
                0:  check("wide r0 key", 32'(key_out16), 32'h1234);
                2:  check("wide r2 key", 32'(key_out16), 32'hB89E);
                5:  check("wide r5 key", 32'(key_out16), 32'h1253);
                7:  check("wide r7 key", 32'(key_out16), 32'h3412);
                11: check("wide r11 key", 32'(key_out16), 32'h1234);
                default: ;
            endcase
            tick();
        end
        check("wide done", 32'(done16), 32'd1);
        tick();
        check("wide idle", 32'(busy16), 32'd0);

        // Single-round configuration
        start4 = 1'b1; key_in4 = 4'h5; chain4 = 1'b0; ready4 = 1'b1;
        tick();
        start4 = 1'b0;
        check("one key", 32'(key_out4), 32'h5);
        check("one idx", 32'(idx4), 32'd0);
        check("one valid", 32'(valid4), 32'd1);
        check("one last", 32'(last4), 32'd1);
        tick();
        check("one done", 32'(done4), 32'd1);
        check("one done valid", 32'(valid4), 32'd0);
        tick();
        check("one idle", 32'(busy4), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
